// File: rtl/clk_div_pkg.sv
// Shared helpers for the clock divider: counter width and high-phase length.
`timescale 1ns/1ps
package clk_div_pkg;

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic int half(input int div);
    return (div % 2 == 0) ? div / 2 : (div - 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Wrapping phase counter 0..DIV_NUM-1; resets to the last phase so the
// first posedge after release lands on phase 0.
`timescale 1ns/1ps
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int DIV_NUM = 2,
  parameter int W = cnt_width(DIV_NUM)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt_next
);

  localparam logic [W-1:0] LAST = W'(DIV_NUM - 1);

  logic [W-1:0] cnt;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clk_div.sv
// Integer clock divider with 50% duty for even and odd ratios; odd ratios
// stretch the high phase by half a cycle with a negedge flop.
`timescale 1ns/1ps
module clk_div
  import clk_div_pkg::*;
#(
  parameter int DIV_NUM = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out
);

  localparam int W = cnt_width(DIV_NUM);
  localparam int H = half(DIV_NUM);
  localparam logic [W-1:0] HV = W'(H);

  if (DIV_NUM < 2) begin : g_bad
    $error("clk_div: DIV_NUM must be at least 2");
  end

  logic [W-1:0] cnt_next;
  logic         p;

  clk_div_cnt #(
    .DIV_NUM(DIV_NUM),
    .W      (W)
  ) u_cnt (
    .clk     (clk_in),
    .rst_n   (rst_n),
    .cnt_next(cnt_next)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      p <= 1'b0;
    end else begin
      p <= (cnt_next < HV);
    end
  end

  if (DIV_NUM % 2 == 1) begin : g_odd
    logic n;

    // n trails p by half a cycle, so p|n never toggles on one edge twice
    always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        n <= 1'b0;
      end else begin
        n <= p;
      end
    end

    assign clk_out = p | n;
  end else begin : g_even
    assign clk_out = p;
  end

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: edge timestamps and a time-based reference waveform.
`timescale 1ns/1ps
module tb_clk_div;

  logic clk = 1'b0;
  logic rst_n, rst_r, rst_x;
  logic o2, o3, o4, o5, o5r, o7, o9;

  int total = 0;
  int bad = 0;

  longint r2[$], f2[$], r3[$], f3[$], r4[$], f4[$];
  longint r5[$], f5[$], r5r[$], f5r[$], r7[$], f7[$];

  clk_div #(.DIV_NUM(2)) u2  (.clk_in(clk), .rst_n(rst_n), .clk_out(o2));
  clk_div #(.DIV_NUM(3)) u3  (.clk_in(clk), .rst_n(rst_n), .clk_out(o3));
  clk_div #(.DIV_NUM(4)) u4  (.clk_in(clk), .rst_n(rst_n), .clk_out(o4));
  clk_div #(.DIV_NUM(5)) u5  (.clk_in(clk), .rst_n(rst_n), .clk_out(o5));
  clk_div #(.DIV_NUM(5)) u5r (.clk_in(clk), .rst_n(rst_r), .clk_out(o5r));
  clk_div #(.DIV_NUM(7)) u7  (.clk_in(clk), .rst_n(rst_n), .clk_out(o7));
  clk_div #(.DIV_NUM(9)) u9  (.clk_in(clk), .rst_n(rst_x), .clk_out(o9));

  initial begin
    #15;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  always @(posedge o2)  if ($time > 2) r2.push_back(longint'($time));
  always @(negedge o2)  if ($time > 2) f2.push_back(longint'($time));
  always @(posedge o3)  if ($time > 2) r3.push_back(longint'($time));
  always @(negedge o3)  if ($time > 2) f3.push_back(longint'($time));
  always @(posedge o4)  if ($time > 2) r4.push_back(longint'($time));
  always @(negedge o4)  if ($time > 2) f4.push_back(longint'($time));
  always @(posedge o5)  if ($time > 2) r5.push_back(longint'($time));
  always @(negedge o5)  if ($time > 2) f5.push_back(longint'($time));
  always @(posedge o5r) if ($time > 2) r5r.push_back(longint'($time));
  always @(negedge o5r) if ($time > 2) f5r.push_back(longint'($time));
  always @(posedge o7)  if ($time > 2) r7.push_back(longint'($time));
  always @(negedge o7)  if ($time > 2) f7.push_back(longint'($time));

  task automatic wait_until(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  // Ideal divided clock: rises at t0, period d*10 ns, high d*5 ns.
  function automatic logic model(input longint t, input longint t0,
                                 input int d);
    longint dt;
    dt = t - t0;
    if (dt < 0) return 1'b0;
    return ((dt % (d * 10)) < (d * 5)) ? 1'b1 : 1'b0;
  endfunction

  task automatic test_reset();
    logic [6:0] v;
    wait_until(5);
    v = {o2, o3, o4, o5, o5r, o7, o9};
    total++;
    if (v !== 7'b0) begin
      bad++;
      $display("FAIL reset_t5 outs=%b want=%b", v, 7'b0);
    end
    wait_until(10);
    rst_n = 1'b1;
    rst_r = 1'b1;
    wait_until(14);
    v = {o2, o3, o4, o5, o5r, o7, o9};
    total++;
    if (v !== 7'b0) begin
      bad++;
      $display("FAIL reset_t14 outs=%b want=%b", v, 7'b0);
    end
    wait_until(17);
    v = {o2, o3, o4, o5, o5r, o7, o9};
    total++;
    if (v !== 7'b1111110) begin
      bad++;
      $display("FAIL first_rise_t17 outs=%b want=%b", v, 7'b1111110);
    end
  endtask

  task automatic test_reset_mid();
    wait_until(30);
    rst_r = 1'b0;
    #1;
    total++;
    if (o5r !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_t31 got=%b want=0", o5r);
    end
    total++;
    if (o5 !== 1'b1) begin
      bad++;
      $display("FAIL ref_div5_t31 got=%b want=1", o5);
    end
    wait_until(51);
    total++;
    if (o5r !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_t51 got=%b want=0", o5r);
    end
    wait_until(52);
    rst_r = 1'b1;
    wait_until(131);
    total++;
    if (r5r.size() < 3 || f5r.size() < 2) begin
      bad++;
      $display("FAIL mid_reset_edges rises=%0d falls=%0d want>=3/2",
               r5r.size(), f5r.size());
    end else begin
      total++;
      if (r5r[0] !== 64'sd15) begin
        bad++;
        $display("FAIL mid_rise0 got=%0d want=15", r5r[0]);
      end
      total++;
      if (f5r[0] !== 64'sd30) begin
        bad++;
        $display("FAIL mid_fall0 got=%0d want=30", f5r[0]);
      end
      total++;
      if (r5r[1] !== 64'sd55) begin
        bad++;
        $display("FAIL mid_rise1 got=%0d want=55", r5r[1]);
      end
      total++;
      if (f5r[1] !== 64'sd80) begin
        bad++;
        $display("FAIL mid_fall1 got=%0d want=80", f5r[1]);
      end
      total++;
      if (r5r[2] !== 64'sd105) begin
        bad++;
        $display("FAIL mid_rise2 got=%0d want=105", r5r[2]);
      end
    end
  endtask

  task automatic test_random_reset();
    longint trel, t0, t;
    int ns;
    logic exp;
    for (int tr = 0; tr < 20; tr++) begin
      #($urandom_range(1, 40));
      while (longint'($time) % 10 == 5) #1;
      rst_x = 1'b1;
      trel = longint'($time);
      t0 = trel + ((5 - (trel % 10)) + 10) % 10;
      ns = $urandom_range(3, 8);
      for (int s = 0; s < ns; s++) begin
        #($urandom_range(1, 60));
        while (longint'($time) % 5 == 0) #1;
        t = longint'($time);
        exp = model(t, t0, 9);
        total++;
        if (o9 !== exp) begin
          bad++;
          $display("FAIL rand_div9 t=%0d rel=%0d got=%b want=%b",
                   t, trel, o9, exp);
        end
      end
      #($urandom_range(1, 30));
      while (longint'($time) % 5 == 0) #1;
      rst_x = 1'b0;
      #1;
      total++;
      if (o9 !== 1'b0) begin
        bad++;
        $display("FAIL rand_assert t=%0d got=%b want=0", $time, o9);
      end
      #($urandom_range(2, 20));
      total++;
      if (o9 !== 1'b0) begin
        bad++;
        $display("FAIL rand_hold t=%0d got=%b want=0", $time, o9);
      end
    end
  endtask

  task automatic test_div2();
    total++;
    if (r2.size() < 101 || f2.size() < 100) begin
      bad++;
      $display("FAIL div2_count rises=%0d falls=%0d want>=101/100",
               r2.size(), f2.size());
    end else begin
      for (int k = 0; k <= 100; k++) begin
        total++;
        if (r2[k] !== longint'(15 + 20 * k)) begin
          bad++;
          $display("FAIL div2_rise k=%0d got=%0d want=%0d",
                   k, r2[k], 15 + 20 * k);
        end
      end
      for (int k = 0; k < 100; k++) begin
        total++;
        if (f2[k] !== longint'(25 + 20 * k)) begin
          bad++;
          $display("FAIL div2_fall k=%0d got=%0d want=%0d",
                   k, f2[k], 25 + 20 * k);
        end
      end
    end
  endtask

  task automatic test_div5();
    total++;
    if (r5.size() < 20 || f5.size() < 20) begin
      bad++;
      $display("FAIL div5_count rises=%0d falls=%0d want>=20",
               r5.size(), f5.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        total++;
        if (r5[k] !== longint'(15 + 50 * k)) begin
          bad++;
          $display("FAIL div5_rise k=%0d got=%0d want=%0d",
                   k, r5[k], 15 + 50 * k);
        end
        total++;
        if (f5[k] !== longint'(40 + 50 * k)) begin
          bad++;
          $display("FAIL div5_fall k=%0d got=%0d want=%0d",
                   k, f5[k], 40 + 50 * k);
        end
      end
    end
  endtask

  task automatic test_div3_4();
    total++;
    if (r3.size() < 20 || f3.size() < 20 ||
        r4.size() < 20 || f4.size() < 20) begin
      bad++;
      $display("FAIL div34_count r3=%0d f3=%0d r4=%0d f4=%0d want>=20",
               r3.size(), f3.size(), r4.size(), f4.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        total++;
        if (r3[k] !== longint'(15 + 30 * k)) begin
          bad++;
          $display("FAIL div3_rise k=%0d got=%0d want=%0d",
                   k, r3[k], 15 + 30 * k);
        end
        total++;
        if (f3[k] !== longint'(30 + 30 * k)) begin
          bad++;
          $display("FAIL div3_fall k=%0d got=%0d want=%0d",
                   k, f3[k], 30 + 30 * k);
        end
        total++;
        if (r4[k] !== longint'(15 + 40 * k)) begin
          bad++;
          $display("FAIL div4_rise k=%0d got=%0d want=%0d",
                   k, r4[k], 15 + 40 * k);
        end
        total++;
        if (f4[k] !== longint'(35 + 40 * k)) begin
          bad++;
          $display("FAIL div4_fall k=%0d got=%0d want=%0d",
                   k, f4[k], 35 + 40 * k);
        end
      end
    end
  endtask

  task automatic test_glitch7();
    int n_in;
    n_in = 0;
    foreach (r7[i]) if (r7[i] < 64'sd70015) n_in++;
    total++;
    if (n_in !== 1000) begin
      bad++;
      $display("FAIL div7_rise_count got=%0d want=1000", n_in);
    end
    total++;
    if (r7.size() < 1000 || f7.size() < 1000) begin
      bad++;
      $display("FAIL div7_count rises=%0d falls=%0d want>=1000",
               r7.size(), f7.size());
    end else begin
      for (int k = 0; k < 1000; k++) begin
        total++;
        if (r7[k] !== longint'(15 + 70 * k)) begin
          bad++;
          $display("FAIL div7_rise k=%0d got=%0d want=%0d",
                   k, r7[k], 15 + 70 * k);
        end
        total++;
        if (f7[k] !== longint'(50 + 70 * k)) begin
          bad++;
          $display("FAIL div7_fall k=%0d got=%0d want=%0d",
                   k, f7[k], 50 + 70 * k);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    rst_r = 1'b1;
    rst_x = 1'b1;
    #1;
    rst_n = 1'b0;
    rst_r = 1'b0;
    rst_x = 1'b0;
    test_reset();
    test_reset_mid();
    test_random_reset();
    wait_until(70100);
    test_div2();
    test_div5();
    test_div3_4();
    test_glitch7();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
